uart_rx_bit_sample: RTL and testbench



---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_sync2.sv | 31 +++
 rtl/uart_rx_bit_sample.sv | 153 +++++++++++++++
 tb/tb_uart_rx_bit_sample.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions used by the RX framing engine and the TX FSM.
//   - uart_state_e   : frame state encoding (IDLE, START, DATA, STOP)
//   - OVERSAMPLE_DEF : default counter_tick pulses per bit period
//   - DATA_BITS_DEF  : default data bits per frame
//   - START_BIT / STOP_BIT : serial line levels of the framing bits
package uart_pkg;

  localparam int unsigned OVERSAMPLE_DEF = 16;
  localparam int unsigned DATA_BITS_DEF  = 8;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input.
// Ports:
//   clk      : destination clock
//   areset_n : asynchronous active-low reset; both flops load RESET_VAL
//   d        : asynchronous input
//   q        : synchronized output (2 clk latency)
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic areset_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx_bit_sample.sv
// UART receive framing engine. Qualifies the start bit at mid-bit, samples
// each data bit (LSB first) at mid-bit, checks the stop bit and presents the
// assembled byte with a one-cycle strobe.
// Ports:
//   clk          : system clock
//   areset_n     : asynchronous active-low reset
//   rx           : asynchronous serial line, idle high
//   counter_tick : single-cycle pulse at OVERSAMPLE x baud
//   rx_data      : last received byte, held until the next frame completes
//   rx_valid     : one-cycle strobe, rx_data updated
//   frame_err    : one-cycle strobe with rx_valid, stop bit sampled low
//   busy         : high whenever the FSM is not IDLE
module uart_rx_bit_sample
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = DATA_BITS_DEF,
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic                 clk,
  input  logic                 areset_n,
  input  logic                 rx,
  input  logic                 counter_tick,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int unsigned SW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int unsigned NW = (DATA_BITS > 1)  ? $clog2(DATA_BITS)  : 1;

  localparam logic [SW-1:0] S_HALF = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_FULL = SW'(OVERSAMPLE - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DATA_BITS - 1);

  logic rx_s;

  uart_sync2 #(.RESET_VAL(1'b1)) u_rx_sync (
    .clk      (clk),
    .areset_n (areset_n),
    .d        (rx),
    .q        (rx_s)
  );

  uart_state_e          state_q,     state_d;
  logic [SW-1:0]        s_q,         s_d;
  logic [NW-1:0]        n_q,         n_d;
  logic [DATA_BITS-1:0] shift_q,     shift_d;
  logic [DATA_BITS-1:0] rx_data_q,   rx_data_d;
  logic                 rx_valid_q,  rx_valid_d;
  logic                 frame_err_q, frame_err_d;

  // Shift right with the new bit entering at the MSB; written through a
  // widened vector so a single-bit frame needs no special case.
  logic [DATA_BITS:0] shift_in;
  assign shift_in = {rx_s, shift_q};

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_q     <= IDLE;
      s_q         <= '0;
      n_q         <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      n_q         <= n_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    n_d         = n_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Falling edge is acted on every clk, not only on ticks.
        if (rx_s == START_BIT) begin
          s_d     = '0;
          state_d = START;
        end
      end

      START: begin
        if (counter_tick) begin
          if (s_q == S_HALF) begin
            if (rx_s == START_BIT) begin
              s_d     = '0;
              n_d     = '0;
              state_d = DATA;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end

      DATA: begin
        if (counter_tick) begin
          if (s_q == S_FULL) begin
            s_d     = '0;
            shift_d = shift_in[DATA_BITS:1];
            if (n_q == N_LAST) begin
              state_d = STOP;
            end else begin
              n_d = n_q + 1'b1;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end

      STOP: begin
        if (counter_tick) begin
          if (s_q == S_FULL) begin
            // Leaving at stop mid-bit so a back-to-back start edge is seen.
            rx_data_d   = shift_q;
            rx_valid_d  = 1'b1;
            frame_err_d = (rx_s != STOP_BIT);
            state_d     = IDLE;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_bit_sample.sv
module tb_uart_rx_bit_sample;

  logic       clk = 1'b0;
  logic       areset_n = 1'b0;
  logic       rx = 1'b1;
  logic       counter_tick = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int strobes = 0;

  typedef struct packed {
    logic [7:0] data;
    logic       ferr;
  } exp_t;

  exp_t exp_q[$];

  logic [1:0] tcnt = 2'd0;
  logic       tick_en = 1'b1;

  uart_rx_bit_sample #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
    .clk          (clk),
    .areset_n     (areset_n),
    .rx           (rx),
    .counter_tick (counter_tick),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .frame_err    (frame_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // One tick every 4 clk while enabled.
  always @(posedge clk) begin
    tcnt         <= tcnt + 2'd1;
    counter_tick <= tick_en && (tcnt == 2'd3);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Strobe monitor: every rx_valid pops one expected frame.
  always @(negedge clk) begin
    if (areset_n && rx_valid === 1'b1) begin
      strobes++;
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", 32'(rx_data), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rx_data", 32'(rx_data), 32'(e.data));
        check("frame_err", 32'(frame_err), 32'(e.ferr));
        check("busy_at_strobe", 32'(busy), 32'd0);
      end
    end
  end

  // Returns just after the posedge on which the DUT consumed a tick.
  task automatic wait_tick();
    do @(negedge clk); while (counter_tick !== 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ticks(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) wait_tick();
  endtask

  // pause_bit / reset_bit select a data bit at whose middle the tick stream
  // stalls for 200 clk or reset is pulsed (-1 = none).
  task automatic send_frame(input logic [7:0] data, input logic stop_val,
                            input int pause_bit, input int reset_bit);
    exp_t e;
    if (reset_bit < 0) begin
      e.data = data;
      e.ferr = ~stop_val;
      exp_q.push_back(e);
    end
    rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      wait_ticks(8);
      if (i == 0) begin
        @(negedge clk);
        check("busy_mid_frame", 32'(busy), 32'd1);
      end
      if (i == pause_bit) begin
        tick_en = 1'b0;
        repeat (200) @(posedge clk);
        #1;
        tick_en = 1'b1;
      end
      if (i == reset_bit) begin
        areset_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_rx_data", 32'(rx_data), 32'd0);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        areset_n = 1'b1;
      end
      wait_ticks(8);
    end
    if (stop_val) begin
      rx = 1'b1;
      wait_ticks(16);
    end else begin
      // Low past the stop sample, then back high before a re-armed START
      // reaches its qualification point.
      rx = 1'b0;
      wait_ticks(10);
      rx = 1'b1;
      wait_ticks(6);
    end
  endtask

  initial begin
    rx = 1'b1;
    areset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_rx_data", 32'(rx_data), 32'd0);
    check("reset_rx_valid", 32'(rx_valid), 32'd0);
    check("reset_frame_err", 32'(frame_err), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    areset_n = 1'b1;
    wait_ticks(20);

    // Glitch: 5 ticks low is rejected at the start qualification point.
    rx = 1'b0;
    wait_ticks(3);
    @(negedge clk);
    check("busy_in_start", 32'(busy), 32'd1);
    wait_ticks(2);
    rx = 1'b1;
    wait_ticks(10);
    @(negedge clk);
    check("glitch_busy", 32'(busy), 32'd0);
    check("glitch_rx_data", 32'(rx_data), 32'd0);
    check("glitch_no_strobe", 32'(strobes), 32'd0);

    send_frame(8'hA5, 1'b1, -1, -1);
    wait_ticks(20);
    @(negedge clk);
    check("a5_hold_data", 32'(rx_data), 32'hA5);
    check("a5_idle_busy", 32'(busy), 32'd0);

    send_frame(8'h3C, 1'b0, -1, -1);
    wait_ticks(20);

    send_frame(8'h00, 1'b1, -1, -1);
    send_frame(8'hFF, 1'b1, -1, -1);
    wait_ticks(20);

    send_frame(8'hF0, 1'b1, -1, 4);
    wait_ticks(20);
    @(negedge clk);
    check("abort_no_strobe", 32'(strobes), 32'd4);
    check("abort_rx_data", 32'(rx_data), 32'd0);

    send_frame(8'h5A, 1'b1, -1, -1);
    wait_ticks(20);

    send_frame(8'h81, 1'b1, 3, -1);
    wait_ticks(20);

    @(negedge clk);
    check("pending_expected", 32'(exp_q.size()), 32'd0);
    check("strobe_total", 32'(strobes), 32'd6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
